// File: rtl/pulse_seq_ctrl.sv
// rtl/pulse_seq_ctrl.sv - double-pulse shot sequencer: edge/period/repeat registers, trigger FSM, progress flags
// Optional registered gate window is built only when PULSE_SEQ_GATE_EN is defined.
module pulse_seq_ctrl #(
  parameter int TW      = 32,
  parameter int RW      = 16,
  parameter int TRIG_HI = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [31:0]   cfg_wdata,
  input  logic          cmd_start,
  input  logic          cmd_abort,
  output logic [TW-1:0] p_start1,
  output logic [TW-1:0] p_end1,
  output logic [TW-1:0] p_start2,
  output logic [TW-1:0] p_end2,
  output logic          trig,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [RW-1:0] shot_cnt,
  output logic          gate
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_DONE} state_t;

  // All-ones is never reached by the generator's counter, so its output stays low.
  localparam logic [TW-1:0] PARK = '1;

  state_t        state_q, state_d;

  logic [TW-1:0] cfg_start1_q, cfg_start1_d;
  logic [TW-1:0] cfg_end1_q, cfg_end1_d;
  logic [TW-1:0] cfg_start2_q, cfg_start2_d;
  logic [TW-1:0] cfg_end2_q, cfg_end2_d;
  logic [TW-1:0] cfg_period_q, cfg_period_d;
  logic [RW-1:0] cfg_repeat_q, cfg_repeat_d;

  logic [TW-1:0] p_start1_q, p_start1_d;
  logic [TW-1:0] p_end1_q, p_end1_d;
  logic [TW-1:0] p_start2_q, p_start2_d;
  logic [TW-1:0] p_end2_q, p_end2_d;
  logic [TW-1:0] period_q, period_d;
  logic [RW-1:0] repeat_q, repeat_d;

  logic [TW-1:0] tc_q, tc_d;
  logic [RW-1:0] shot_q, shot_d;
  logic          err_q, err_d;
  logic          busy_w;
  logic          cfg_ok;

  assign busy_w = (state_q == ST_ARM) || (state_q == ST_RUN);

  assign cfg_ok = (cfg_start1_q < cfg_end1_q) && (cfg_end1_q < cfg_start2_q) &&
                  (cfg_start2_q < cfg_end2_q) && (cfg_end2_q < cfg_period_q) &&
                  (cfg_repeat_q != '0);

  always_comb begin
    cfg_start1_d = cfg_start1_q;
    cfg_end1_d   = cfg_end1_q;
    cfg_start2_d = cfg_start2_q;
    cfg_end2_d   = cfg_end2_q;
    cfg_period_d = cfg_period_q;
    cfg_repeat_d = cfg_repeat_q;
    if (cfg_we && !busy_w) begin
      case (cfg_addr)
        3'd0:    cfg_start1_d = cfg_wdata[TW-1:0];
        3'd1:    cfg_end1_d   = cfg_wdata[TW-1:0];
        3'd2:    cfg_start2_d = cfg_wdata[TW-1:0];
        3'd3:    cfg_end2_d   = cfg_wdata[TW-1:0];
        3'd4:    cfg_period_d = cfg_wdata[TW-1:0];
        3'd5:    cfg_repeat_d = cfg_wdata[RW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    tc_d       = tc_q;
    shot_d     = shot_q;
    err_d      = 1'b0;
    p_start1_d = p_start1_q;
    p_end1_d   = p_end1_q;
    p_start2_d = p_start2_q;
    p_end2_d   = p_end2_q;
    period_d   = period_q;
    repeat_d   = repeat_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start && !cmd_abort) begin
          if (cfg_ok) begin
            p_start1_d = cfg_start1_q;
            p_end1_d   = cfg_end1_q;
            p_start2_d = cfg_start2_q;
            p_end2_d   = cfg_end2_q;
            period_d   = cfg_period_q;
            repeat_d   = cfg_repeat_q;
            shot_d     = '0;
            tc_d       = '0;
            state_d    = ST_ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ARM: begin
        // tc doubles as the trigger-high counter while armed
        if (tc_q == TW'(TRIG_HI - 1)) begin
          tc_d    = '0;
          state_d = ST_RUN;
        end else begin
          tc_d = tc_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (tc_q == period_q - 1'b1) begin
          shot_d = shot_q + 1'b1;
          tc_d   = '0;
          if (shot_d == repeat_q) begin
            state_d    = ST_DONE;
            p_start1_d = PARK;
            p_end1_d   = PARK;
            p_start2_d = PARK;
            p_end2_d   = PARK;
          end else begin
            state_d = ST_ARM;
          end
        end else begin
          tc_d = tc_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (cmd_abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      tc_d       = tc_q;
      shot_d     = shot_q;
      p_start1_d = PARK;
      p_end1_d   = PARK;
      p_start2_d = PARK;
      p_end2_d   = PARK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cfg_start1_q <= '0;
      cfg_end1_q   <= '0;
      cfg_start2_q <= '0;
      cfg_end2_q   <= '0;
      cfg_period_q <= '0;
      cfg_repeat_q <= '0;
      p_start1_q   <= PARK;
      p_end1_q     <= PARK;
      p_start2_q   <= PARK;
      p_end2_q     <= PARK;
      period_q     <= '0;
      repeat_q     <= '0;
      tc_q         <= '0;
      shot_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_start1_q <= cfg_start1_d;
      cfg_end1_q   <= cfg_end1_d;
      cfg_start2_q <= cfg_start2_d;
      cfg_end2_q   <= cfg_end2_d;
      cfg_period_q <= cfg_period_d;
      cfg_repeat_q <= cfg_repeat_d;
      p_start1_q   <= p_start1_d;
      p_end1_q     <= p_end1_d;
      p_start2_q   <= p_start2_d;
      p_end2_q     <= p_end2_d;
      period_q     <= period_d;
      repeat_q     <= repeat_d;
      tc_q         <= tc_d;
      shot_q       <= shot_d;
      err_q        <= err_d;
    end
  end

`ifdef PULSE_SEQ_GATE_EN
  logic gate_q, gate_d;

  // Looks at next-cycle state/tc so the flop lines up with the generator's window.
  always_comb begin
    gate_d = (state_d == ST_RUN) && (tc_d >= p_start1_q) && (tc_d <= p_end2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gate_q <= 1'b0;
    else        gate_q <= gate_d;
  end

  assign gate = gate_q;
`else
  assign gate = 1'b0;
`endif

  assign trig     = (state_q == ST_ARM);
  assign busy     = busy_w;
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign shot_cnt = shot_q;
  assign p_start1 = p_start1_q;
  assign p_end1   = p_end1_q;
  assign p_start2 = p_start2_q;
  assign p_end2   = p_end2_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// tb/tb_pulse_seq_ctrl.sv - randomized and directed bench for pulse_seq_ctrl against a timeline model
module tb_pulse_seq_ctrl;
  localparam int TW = 32;
  localparam int RW = 16;
  localparam int TH = 2;
  localparam logic [31:0] PARK = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic          cmd_start = 1'b0;
  logic          cmd_abort = 1'b0;
  logic [TW-1:0] p_start1, p_end1, p_start2, p_end2;
  logic          trig, busy, done, err, gate;
  logic [RW-1:0] shot_cnt;

  pulse_seq_ctrl #(.TW(TW), .RW(RW), .TRIG_HI(TH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .p_start1(p_start1), .p_end1(p_end1), .p_start2(p_start2), .p_end2(p_end2),
    .trig(trig), .busy(busy), .done(done), .err(err), .shot_cnt(shot_cnt), .gate(gate)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a sequence started in cycle s is a fixed schedule of
  // repeat shots of (TH trigger cycles + period run cycles), then one done cycle.
  logic [31:0] m_cfg [6];
  logic [31:0] m_sh  [6];
  bit          m_act = 0;
  longint      m_s = 0;
  longint      cyc = 0;
  logic [15:0] m_hold = '0;
  bit          e_trig = 0, e_busy = 0, e_done = 0, e_err = 0, e_gate = 0;
  logic [15:0] e_shot = '0;
  logic [31:0] e_p [4];
  bit          m_idle, m_nerr, m_ok;
  longint      m_len, m_el, m_tot, m_r, m_tc;

  initial begin
    foreach (m_cfg[i]) m_cfg[i] = '0;
    foreach (m_sh[i]) m_sh[i] = '0;
    foreach (e_p[i]) e_p[i] = PARK;
    forever begin
      @(posedge clk);
      m_nerr = 0;
      if (!rst_n) begin
        foreach (m_cfg[i]) m_cfg[i] = '0;
        m_act  = 0;
        m_hold = '0;
      end else begin
        m_idle = !e_busy && !e_done;
        m_ok = (m_cfg[0] < m_cfg[1]) && (m_cfg[1] < m_cfg[2]) && (m_cfg[2] < m_cfg[3]) &&
               (m_cfg[3] < m_cfg[4]) && (m_cfg[5] != 0);
        if (!m_idle && cmd_abort) begin
          m_act  = 0;
          m_hold = e_shot;
        end else if (m_idle && cmd_start && !cmd_abort) begin
          if (m_ok) begin
            m_act = 1;
            m_s   = cyc + 1;
            m_sh  = m_cfg;
          end else begin
            m_nerr = 1;
          end
        end
        if (!e_busy && cfg_we && cfg_addr < 3'd6)
          m_cfg[cfg_addr] = (cfg_addr == 3'd5) ? (cfg_wdata & 32'h0000_FFFF) : cfg_wdata;
      end
      cyc++;
      e_trig = 0; e_busy = 0; e_done = 0; e_gate = 0; e_err = m_nerr;
      if (m_act) begin
        m_len = longint'(m_sh[4]) + TH;
        m_el  = cyc - m_s;
        m_tot = longint'(m_sh[5]) * m_len;
        if (m_el < m_tot) begin
          m_r    = m_el % m_len;
          e_busy = 1;
          e_trig = (m_r < TH);
          e_shot = 16'(m_el / m_len);
          for (int i = 0; i < 4; i++) e_p[i] = m_sh[i];
`ifdef PULSE_SEQ_GATE_EN
          if (m_r >= TH) begin
            m_tc   = m_r - TH;
            e_gate = (m_tc >= longint'(m_sh[0])) && (m_tc <= longint'(m_sh[3]));
          end
`endif
        end else if (m_el == m_tot) begin
          e_done = 1;
          e_shot = m_sh[5][15:0];
          for (int i = 0; i < 4; i++) e_p[i] = PARK;
        end else begin
          m_act  = 0;
          m_hold = m_sh[5][15:0];
        end
      end
      if (!m_act) begin
        e_shot = m_hold;
        for (int i = 0; i < 4; i++) e_p[i] = PARK;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("trig", trig, e_trig);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("err", err, e_err);
        check("shot_cnt", shot_cnt, e_shot);
        check("p_start1", p_start1, e_p[0]);
        check("p_end1", p_end1, e_p[1]);
        check("p_start2", p_start2, e_p[2]);
        check("p_end2", p_end2, e_p[3]);
        check("gate", gate, e_gate);
      end
    end
  end

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic base_cfg(input int rep);
    wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40); wr(4, 100); wr(5, rep);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_gate", gate, 0);
    check("rst_shot", shot_cnt, 0);
    check("rst_p_start1", p_start1, PARK);
    check("rst_p_end2", p_end2, PARK);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    check(name, busy, 0);
  endtask

  initial begin
    int n, hi, nf, nd, prev;
    int falls [$];
    logic [31:0] s1, e1, s2, e2, per, rep;

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    do_reset();

    // single shot
    base_cfg(1);
    pulse_start();
    check("single_trig_rise", trig, 1);
    n = 0; hi = trig ? 1 : 0;
    while (!done && n < 400) begin @(negedge clk); n++; if (trig) hi++; end
    check("single_done_lat", n, 102);
    check("single_trig_hi", hi, 2);
    check("single_shot_cnt", shot_cnt, 1);
    @(negedge clk);
    check("single_parked", p_start1, PARK);
    check("single_idle", busy, 0);

    // burst of three
    wr(5, 3);
    pulse_start();
    falls.delete(); n = 0; nd = 0; prev = trig;
    while (!done && n < 1000) begin
      @(negedge clk); n++;
      if (prev && !trig) falls.push_back(n);
      prev = trig;
    end
    for (int i = 0; i < 5; i++) begin if (done) nd++; @(negedge clk); end
    check("burst_falls", falls.size(), 3);
    if (falls.size() == 3) begin
      check("burst_gap1", falls[1] - falls[0], 102);
      check("burst_gap2", falls[2] - falls[1], 102);
    end
    check("burst_done_lat", n, 306);
    check("burst_done_cnt", nd, 1);
    check("burst_shot_cnt", shot_cnt, 3);

    // busy lockout: write and start mid-run are dropped
    pulse_start();
    n = 0;
    repeat (20) begin @(negedge clk); n++; end
    wr(4, 500); n += 2;
    pulse_start(); n += 2;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    check("lockout_done_lat", n, 306);

    // abort at tc=50 of shot 2
    @(negedge clk);
    pulse_start();
    nf = 0; n = 0; prev = trig;
    while (nf < 2 && n < 400) begin
      @(negedge clk); n++;
      if (prev && !trig) nf++;
      prev = trig;
    end
    check("abort_falls", nf, 2);
    repeat (50) @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_trig", trig, 0);
    check("abort_shot", shot_cnt, 1);
    check("abort_parked", p_end1, PARK);
    nd = 0;
    repeat (20) begin @(negedge clk); if (done) nd++; end
    check("abort_no_done", nd, 0);

    // invalid config
    wr(1, 5);
    pulse_start();
    check("inv_err", err, 1);
    check("inv_busy", busy, 0);
    hi = 0;
    repeat (20) begin @(negedge clk); if (trig) hi++; end
    check("inv_no_trig", hi, 0);
    wr(1, 20);

    // abort beats start in idle
    @(negedge clk);
    cmd_start = 1'b1; cmd_abort = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_abort = 1'b0;
    check("abort_wins", busy, 0);

    // reset mid-run clears config
    pulse_start();
    repeat (30) @(negedge clk);
    do_reset();
    pulse_start();
    check("post_rst_err", err, 1);
    check("post_rst_busy", busy, 0);

    // randomized episodes
    for (int ep = 0; ep < 25; ep++) begin
      wait_idle("rand_idle_pre");
      s1  = $urandom_range(0, 8);
      e1  = s1 + $urandom_range(1, 6);
      s2  = e1 + $urandom_range(1, 6);
      e2  = s2 + $urandom_range(1, 6);
      per = e2 + $urandom_range(1, 10);
      rep = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) e1 = s1;
      wr(0, s1); wr(1, e1); wr(2, s2); wr(3, e2); wr(4, per); wr(5, rep);
      pulse_start();
      repeat (120) begin
        @(negedge clk);
        cmd_start = ($urandom_range(0, 24) == 0);
        cmd_abort = ($urandom_range(0, 89) == 0);
        cfg_we    = ($urandom_range(0, 11) == 0);
        cfg_addr  = 3'($urandom_range(0, 7));
        cfg_wdata = $urandom_range(0, 60);
      end
      @(negedge clk);
      cmd_start = 1'b0; cmd_abort = 1'b0; cfg_we = 1'b0;
      wait_idle("rand_idle_post");
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
